// File: rtl/ibuf_pkg.sv
// Shared types and default sizing for the IF/ID instruction buffer.
package ibuf_pkg;

  localparam int unsigned IBUF_DEPTH  = 4;
  localparam int unsigned IBUF_PC_W   = 32;
  localparam int unsigned IBUF_INST_W = 32;

  typedef struct packed {
    logic [IBUF_PC_W-1:0]   pc;
    logic [IBUF_INST_W-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_ram.sv
// Instruction-buffer storage: register array, one synchronous write port,
// one asynchronous read port.
module ibuf_ram
  import ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned WIDTH = $bits(ibuf_entry_t),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_inst_buffer.sv
// IF/ID instruction queue: FWFT FIFO of {pc, inst} with fetch credit tracking
// and branch flush that optionally preserves the delay-slot instruction.
module id_inst_buffer
  import ibuf_pkg::*;
#(
  parameter int unsigned DEPTH      = IBUF_DEPTH,
  parameter int unsigned PC_W       = IBUF_PC_W,
  parameter int unsigned INST_W     = IBUF_INST_W,
  parameter int unsigned DELAY_SLOT = 1,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_req,
  output logic              fetch_allow,
  input  logic              enq_valid,
  input  logic [PC_W-1:0]   enq_pc,
  input  logic [INST_W-1:0] enq_inst,
  input  logic              deq_ready,
  output logic              deq_valid,
  output logic [PC_W-1:0]   deq_pc,
  output logic [INST_W-1:0] deq_inst,
  input  logic              flush,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          keep_one_q, keep_one_d;
  logic          overflow_q, overflow_d;

  logic          deq_valid_c, deq_fire_c, dropping_c, full_c, we_c;
  logic [CW-1:0] surv_c, rem_c;
  entry_t        wr_entry_c, rd_entry_c;

  assign deq_valid_c = (count_q != '0);
  assign deq_fire_c  = deq_valid_c & deq_ready;
  assign full_c      = (count_q == CW'(DEPTH));
  // Drop counter is armed but parked while waiting for the delay-slot response.
  assign dropping_c  = (drop_cnt_q != '0) & !keep_one_q;
  assign surv_c      = count_q - CW'(deq_fire_c);
  assign rem_c       = inflight_q - CW'(enq_valid);
  assign wr_entry_c  = '{pc: enq_pc, inst: enq_inst};

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    keep_one_d = keep_one_q;
    overflow_d = overflow_q;
    we_c       = 1'b0;
    inflight_d = inflight_q + CW'(fetch_req) - CW'(enq_valid);

    if (flush) begin
      // A fetch_req in this cycle is the branch target, so rem_c excludes it.
      rd_ptr_d   = rd_ptr_q + AW'(deq_fire_c);
      keep_one_d = 1'b0;
      drop_cnt_d = rem_c;
      if (DELAY_SLOT == 0) begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end else if (surv_c != '0) begin
        wr_ptr_d = rd_ptr_d + AW'(1);
        count_d  = CW'(1);
      end else if (enq_valid) begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = CW'(1);
      end else begin
        keep_one_d = 1'b1;
        count_d    = '0;
      end
    end else begin
      if (enq_valid && dropping_c) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (enq_valid && full_c && !deq_fire_c) begin
        overflow_d = 1'b1;
      end else if (enq_valid) begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (keep_one_q) begin
          keep_one_d = 1'b0;
          if (drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
          end
        end
      end
      if (deq_fire_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(we_c) - CW'(deq_fire_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      keep_one_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      keep_one_q <= keep_one_d;
      overflow_q <= overflow_d;
    end
  end

  ibuf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INST_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry_c)
  );

  assign deq_valid   = deq_valid_c;
  assign deq_pc      = deq_valid_c ? rd_entry_c.pc : '0;
  assign deq_inst    = deq_valid_c ? rd_entry_c.inst : '0;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign fetch_allow = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);

endmodule

// File: tb/tb_id_inst_buffer.sv
// Randomised and directed bench for id_inst_buffer against a queue-level model.
module tb_id_inst_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn, fetch_req, enq_valid, deq_ready, flush;
  logic [31:0] enq_pc, enq_inst;
  logic        deq_valid, fetch_allow, overflow;
  logic [31:0] deq_pc, deq_inst;
  logic [2:0]  count;
  logic        d0_valid, d0_allow, d0_ovf;
  logic [31:0] d0_pc, d0_inst;
  logic [2:0]  d0_count;

  always #5 clk = ~clk;

  id_inst_buffer #(.DEPTH(DEPTH), .DELAY_SLOT(1)) dut (
    .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .fetch_allow(fetch_allow),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
    .flush(flush), .count(count), .overflow(overflow)
  );

  id_inst_buffer #(.DEPTH(DEPTH), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .fetch_allow(d0_allow),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
    .deq_ready(deq_ready), .deq_valid(d0_valid), .deq_pc(d0_pc), .deq_inst(d0_inst),
    .flush(flush), .count(d0_count), .overflow(d0_ovf)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; bit keep; } req_t;

  ent_t        mq[$];
  req_t        fl_q[$];
  bit          m_ovf;
  logic [31:0] next_pc;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [69:0] obs;

  assign obs = {deq_valid, deq_pc, deq_inst, count, fetch_allow, overflow};

  function automatic logic [69:0] expv();
    bit v;
    ent_t h;
    v = (mq.size() > 0);
    h = v ? mq[0] : '0;
    return {v, h.pc, h.inst, 3'(mq.size()), ((mq.size() + fl_q.size()) < DEPTH), m_ovf};
  endfunction

  function automatic bit m_allow();
    return (mq.size() + fl_q.size()) < DEPTH;
  endfunction

  // Drive one cycle and advance the model; requests carry their own pc/inst
  // so responses come back in issue order.
  task automatic step(input bit fr, input bit ev, input bit dr, input bit fl);
    req_t r;
    ent_t k;
    int   pre;
    bit   fire;
    r = '0;
    fetch_req = fr; enq_valid = ev; deq_ready = dr; flush = fl;
    if (ev) begin
      r = fl_q.pop_front();
      enq_pc = r.pc; enq_inst = r.inst;
    end else begin
      enq_pc = $urandom; enq_inst = $urandom;
    end
    pre  = mq.size();
    fire = dr && (pre > 0);
    if (fire) void'(mq.pop_front());
    if (fl) begin
      foreach (fl_q[i]) fl_q[i].keep = 1'b0;
      if (mq.size() > 0) begin
        k = mq[0]; mq.delete(); mq.push_back(k);
      end else if (ev) begin
        mq.push_back('{pc: r.pc, inst: r.inst});
      end else if (fl_q.size() > 0) begin
        fl_q[0].keep = 1'b1;
      end
    end else if (ev && r.keep) begin
      if (pre == DEPTH && !fire) m_ovf = 1'b1;
      else mq.push_back('{pc: r.pc, inst: r.inst});
    end
    if (fr) begin
      fl_q.push_back('{pc: next_pc, inst: $urandom, keep: 1'b1});
      next_pc = next_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    fetch_req = 0; enq_valid = 0; deq_ready = 0; flush = 0;
    enq_pc = '0; enq_inst = '0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mq.delete(); fl_q.delete(); m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_values got=%h want=%h", obs, {1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_fill();
    next_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      n_checks++;
      if (fetch_allow !== (i < 3)) begin
        n_fail++; $display("FAIL fill_allow i=%0d got=%b want=%b", i, fetch_allow, (i < 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      n_checks++;
      if ({count, fetch_allow, overflow} !== {3'(i + 1), 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL fill_count i=%0d got=%h want=%h", i, {count, fetch_allow, overflow}, {3'(i + 1), 1'b0, 1'b0});
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (deq_pc !== 32'(4 * i) || obs !== expv()) begin
        n_fail++; $display("FAIL fill_order i=%0d got=%h want_pc=%h model=%h", i, obs, 32'(4 * i), expv());
      end
      step(0, 0, 1, 0);
    end
  endtask

  task automatic test_stream();
    next_pc = 32'h100;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0);
      n_checks++;
      if (count !== 3'd1 || deq_pc !== 32'h100 + 32'(4 * i) || obs !== expv()) begin
        n_fail++; $display("FAIL stream i=%0d got=%h model=%h", i, obs, expv());
      end
    end
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (obs !== expv() || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_flush_entries();
    next_pc = 32'h10;
    repeat (4) step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    next_pc = 32'h40;
    step(1, 0, 0, 1);
    n_checks++;
    if (count !== 3'd1 || deq_pc !== 32'h10 || obs !== expv()) begin
      n_fail++; $display("FAIL flush_keep got=%h model=%h", obs, expv());
    end
    step(0, 1, 0, 0);
    n_checks++;
    if (count !== 3'd1 || obs !== expv()) begin
      n_fail++; $display("FAIL flush_drop got=%h model=%h", obs, expv());
    end
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (count !== 3'd1 || deq_pc !== 32'h40 || obs !== expv()) begin
      n_fail++; $display("FAIL flush_target got=%h model=%h", obs, expv());
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_flush_empty();
    next_pc = 32'h24;
    repeat (2) step(1, 0, 0, 0);
    next_pc = 32'h80;
    step(1, 0, 0, 1);
    n_checks++;
    if (deq_valid !== 1'b0 || obs !== expv()) begin
      n_fail++; $display("FAIL fempty_flush got=%h model=%h", obs, expv());
    end
    repeat (3) step(0, 1, 0, 0);
    n_checks++;
    if (count !== 3'd2 || deq_pc !== 32'h24 || obs !== expv()) begin
      n_fail++; $display("FAIL fempty_slot got=%h model=%h", obs, expv());
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (count !== 3'd1 || deq_pc !== 32'h80 || obs !== expv()) begin
      n_fail++; $display("FAIL fempty_target got=%h model=%h", obs, expv());
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_ds0_flush();
    do_reset();
    next_pc = 32'h200;
    repeat (4) step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    n_checks++;
    if (d0_count !== 3'd3) begin
      n_fail++; $display("FAIL ds0_fill got=%0d want=3", d0_count);
    end
    next_pc = 32'h300;
    step(1, 0, 0, 1);
    n_checks++;
    if ({d0_count, d0_valid, d0_pc} !== {3'd0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL ds0_flush got=%h want=%h", {d0_count, d0_valid, d0_pc}, {3'd0, 1'b0, 32'h0});
    end
    step(0, 1, 0, 0);
    n_checks++;
    if (d0_count !== 3'd0) begin
      n_fail++; $display("FAIL ds0_drop got=%0d want=0", d0_count);
    end
    step(0, 1, 0, 0);
    n_checks++;
    if ({d0_count, d0_valid, d0_pc, d0_allow} !== {3'd1, 1'b1, 32'h300, 1'b1}) begin
      n_fail++; $display("FAIL ds0_target got=%h want=%h", {d0_count, d0_valid, d0_pc, d0_allow}, {3'd1, 1'b1, 32'h300, 1'b1});
    end
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL ds0_ds1_model got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_pc = 32'h400;
    repeat (5) step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    n_checks++;
    if (count !== 3'd2 || overflow !== 1'b1 || obs !== expv()) begin
      n_fail++; $display("FAIL rmid_pre got=%h model=%h", obs, expv());
    end
    do_reset();
    n_checks++;
    if (obs !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rmid_post got=%h want=%h", obs, {1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    bit fr, ev, dr, fl;
    do_reset();
    next_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      fr = m_allow() && ($urandom_range(99) < 60);
      ev = (fl_q.size() > 0) && ($urandom_range(99) < 55);
      dr = ($urandom_range(99) < 60);
      fl = ($urandom_range(99) < 6);
      step(fr, ev, dr, fl);
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    m_ovf  = 1'b0;
    test_reset();
    test_fill();
    test_stream();
    test_flush_entries();
    test_flush_empty();
    test_ds0_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_inst_buffer.md
# id_inst_buffer

Parametrised instruction queue between IF and ID. It decouples instruction-SRAM responses from decode stalls and replaces the single-entry stall hold register with a DEPTH-entry FIFO of {pc, inst} pairs. It also tracks outstanding fetches, and on a taken branch it flushes wrong-path instructions while preserving the MIPS delay slot. ID consumes the head combinationally; IF issues requests only while `fetch_allow` is high.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PC_W`, 32: PC width.
- `INST_W`, 32: instruction width.
- `DELAY_SLOT`, 1: 1 keeps the delay-slot instruction on flush; 0 flushes everything.
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `fetch_req` in 1: IF issued an SRAM request this cycle; its response arrives on a later cycle.
- `fetch_allow` out 1: IF may issue a request this cycle.
- `enq_valid` in 1: SRAM response valid this cycle.
- `enq_pc` in PC_W: PC of the response.
- `enq_inst` in INST_W: instruction word of the response.
- `deq_ready` in 1: ID accepts the head this cycle (`!stall[2]`).
- `deq_valid` out 1: head entry is valid.
- `deq_pc` out PC_W: head PC.
- `deq_inst` out INST_W: head instruction.
- `flush` in 1: taken branch or jump resolved in ID (`br_e`).
- `count` out $clog2(DEPTH)+1: occupied entries.
- `overflow` out 1: sticky error flag; enqueue was attempted while full.

## Operation
- Storage is a circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH. `count` is a separate register.
- Head is first-word-fall-through: `deq_*` are driven from the `rd_ptr` entry. `deq_pc`/`deq_inst` are zero when `deq_valid`=0.
- Dequeue occurs when `deq_fire` = `deq_valid & deq_ready`.
- Enqueue occurs when `enq_fire` = `enq_valid & !dropping & !keep_hit_full`. The entry is written at `wr_ptr`.
- `inflight` counter ($clog2(DEPTH)+1 bits): +1 on `fetch_req`, −1 on `enq_valid`, both applied in the same cycle when both occur.
- `fetch_allow` = (`count` + `inflight`) < DEPTH. Every issued request is therefore guaranteed a slot.
- `overflow` sets when `enq_valid` is high, no drop applies, and `count`==DEPTH with no `deq_fire`. The entry is discarded. The flag clears only on reset.
- Flush, DELAY_SLOT=1:
  - Let `surv` = `count` − `deq_fire`.
  - If `surv`≥1: keep only the oldest surviving entry (the delay slot) and discard the rest. A same-cycle `enq_valid` is dropped. `drop_cnt` ← inflight responses remaining after this cycle.
  - If `surv`==0 and `enq_valid`: write that response (it is the delay slot). `drop_cnt` ← remaining inflight.
  - If `surv`==0 and no `enq_valid`: set `keep_one`. The next response is written, then `drop_cnt` ← the remaining inflight at that time.
  - In all cases, a `fetch_req` in the flush cycle is the branch-target fetch. It is excluded from `drop_cnt`.
- Flush, DELAY_SLOT=0: queue empties, any same-cycle enqueue is discarded, and `drop_cnt` ← all remaining inflight responses.
- While `drop_cnt`>0 (`dropping`), each `enq_valid` decrements `drop_cnt` and is not written.
- A flush arriving while `drop_cnt` or `keep_one` is active recomputes both from current state. The new flush wins.
- `deq_fire` in the flush cycle is honoured: the branch instruction itself has already left the queue.

## Timing
- Enqueue-to-dequeue latency is 1 cycle: an entry written at edge N is visible on `deq_*` after edge N. There is no same-cycle bypass.
- Full throughput: 1 enqueue + 1 dequeue per cycle, `count` unchanged.
- Flush takes effect at the next edge. `deq_valid` in the cycle after a flush reflects only the kept delay slot, if any.
- Reset (`resetn`=0 at an edge) clears pointers, `count`, `inflight`, `drop_cnt`, `keep_one` and `overflow` to 0. After reset: `deq_valid`=0, `deq_pc`=0, `deq_inst`=0, `fetch_allow`=1.
- Reset mid-operation abandons all responses: the bench must not present `enq_valid` for pre-reset requests.

## Structure
- Shared package `ibuf_pkg` holds the `ibuf_entry_t` struct {pc, inst} and the default DEPTH, PC_W and INST_W constants.
- Sub-module `ibuf_ram`: DEPTH×(PC_W+INST_W) register array with one write port and an asynchronous read port.
- Pointer, count, inflight and flush/drop control live in `id_inst_buffer`.

## Test plan
- Fill: DEPTH=4. 4 requests, then 4 responses with pc 0x00,0x04,0x08,0x0C and `deq_ready`=0 → `count`=4 and `fetch_allow`=0 once `inflight`+`count` reaches 4; no `overflow`.
- Streaming: `deq_ready`=1 with 1 response per cycle → one instruction per cycle, in pc order, 1-cycle latency; `count` stays 1.
- Flush with entries: queue holds 0x10,0x14,0x18 and 1 inflight; `flush` with no `deq_fire` → next cycle `count`=1, head 0x10; the next response is dropped; the target response 0x40 is enqueued after 0x10.
- Flush while empty: `inflight`=2, queue empty, `flush` → first response (0x24) is kept, second is dropped, third (target) is kept.
- DELAY_SLOT=0 flush: `count`=3 → `count`=0, `deq_valid`=0; all inflight responses are dropped.
- Reset mid-stream: `resetn`=0 while `count`=2 and `overflow`=1 → all outputs return to reset values at the next edge.
